// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its three neighbours: display fetch, CPU bus decode and the VRAM macro.
// The slave modport is the arbiter's view; master is the environment's view.
interface vram_arbiter_if #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int STALL_CNT_W = 16
);
  logic                   disp_req;
  logic [ADDR_W-1:0]      disp_addr;
  logic [DATA_W-1:0]      disp_rdata;
  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DATA_W-1:0]      cpu_wdata;
  logic [DATA_W-1:0]      cpu_rdata;
  logic                   cpu_ack;
  logic                   cpu_wait;
  logic                   ram_ce;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;
  logic                   clr_stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, clr_stall,
    output disp_rdata, cpu_rdata, cpu_ack, cpu_wait, ram_ce, ram_we, ram_addr, ram_wdata, stall_cnt
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, clr_stall,
    input  disp_rdata, cpu_rdata, cpu_ack, cpu_wait, ram_ce, ram_we, ram_addr, ram_wdata, stall_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, the CPU is served in free slots and held with cpu_wait.
// Define VRAM_WRBUF_EN to add a 1-entry posted CPU write buffer with read forwarding.
module vram_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, ACK} state_t;

  state_t                 state_q, state_d;
  logic                   cpu_ack_q;
  logic [DATA_W-1:0]      cpu_rdata_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   cpu_issue;
  logic                   blocked;
  logic                   cpu_phase;

`ifdef VRAM_WRBUF_EN
  logic                   buf_valid_q;
  logic [ADDR_W-1:0]      buf_addr_q;
  logic [DATA_W-1:0]      buf_data_q;
  logic                   fwd_q;
  logic                   capture;
  logic                   fwd;
  logic                   drain;
`endif

  assign cpu_phase      = (state_q == IDLE) || (state_q == ISSUE);
  assign bus.disp_rdata = bus.ram_rdata;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_wait   = bus.cpu_req & ~cpu_ack_q;
  assign bus.stall_cnt  = stall_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    cpu_issue     = 1'b0;
    blocked       = 1'b0;
    bus.ram_ce    = bus.disp_req;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = bus.disp_addr;
    bus.ram_wdata = bus.cpu_wdata;
`ifdef VRAM_WRBUF_EN
    capture = 1'b0;
    fwd     = 1'b0;
    drain   = buf_valid_q & ~bus.disp_req;
    if (drain) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = buf_addr_q;
      bus.ram_wdata = buf_data_q;
    end
`endif

    case (state_q)
      IDLE, ISSUE: begin
        if (bus.cpu_req) begin
`ifdef VRAM_WRBUF_EN
          // Writes always go through the buffer; reads of the buffered address never touch RAM.
          if (bus.cpu_we) begin
            if (!buf_valid_q) capture = 1'b1;
            else              blocked = 1'b1;
          end else if (buf_valid_q && bus.cpu_addr == buf_addr_q) begin
            fwd = 1'b1;
          end else if (!bus.disp_req && !buf_valid_q) begin
            cpu_issue = 1'b1;
          end else begin
            blocked = 1'b1;
          end
`else
          if (!bus.disp_req) cpu_issue = 1'b1;
          else               blocked   = 1'b1;
`endif
          state_d = blocked ? ISSUE : DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA:    state_d = bus.cpu_req ? ACK : IDLE;
      ACK:     if (!bus.cpu_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cpu_issue) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = bus.cpu_we;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_ack_q <= (state_d == ACK);
`ifdef VRAM_WRBUF_EN
      if (fwd)
        cpu_rdata_q <= buf_data_q;
      else if (state_q == DATA && bus.cpu_req && !bus.cpu_we && !fwd_q)
        cpu_rdata_q <= bus.ram_rdata;
`else
      if (state_q == DATA && bus.cpu_req && !bus.cpu_we)
        cpu_rdata_q <= bus.ram_rdata;
`endif
      if (bus.clr_stall)
        stall_q <= '0;
      else if (blocked && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

`ifdef VRAM_WRBUF_EN
  // NOTE: only the valid flag needs reset; address and data are qualified by it, so they are left unreset.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      fwd_q       <= 1'b0;
    end else begin
      if (capture)    buf_valid_q <= 1'b1;
      else if (drain) buf_valid_q <= 1'b0;
      if (cpu_phase)  fwd_q <= fwd;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (capture) begin
      buf_addr_q <= bus.cpu_addr;
      buf_data_q <= bus.cpu_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized CPU traffic against a
// behavioural VRAM and shadow-memory reference model.
module tb_vram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int STALL_CNT_W = 16;

  logic pixel_clock = 1'b0;
  logic reset_n;
  logic ram_init;
  logic [DATA_W-1:0] ram_rdata_q;
  logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_CNT_W(STALL_CNT_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_CNT_W(STALL_CNT_W)) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .bus         (bus.slave)
  );

  always #5 pixel_clock = ~pixel_clock;

  // Power-on content pattern; chosen so that address 0x0123 holds 0x5A.
  function automatic logic [7:0] init_byte(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h78;
  endfunction

  // Behavioural single-port synchronous VRAM with 1-cycle read latency.
  always @(posedge pixel_clock) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) vram[i] <= init_byte(13'(i));
    end else if (bus.ram_ce) begin
      if (bus.ram_we) vram[bus.ram_addr] <= bus.ram_wdata;
      else            ram_rdata_q <= vram[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_rdata_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    cyc++;
  endtask

  task automatic cpu_drive(input logic we, input logic [12:0] a, input logic [7:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  // Directed/random bookkeeping
  bit                active, rel, issued, we_r, prev_disp;
  logic [ADDR_W-1:0] a_r, prev_da;
  logic [DATA_W-1:0] d_r;
  int                issue_cyc, start_cyc, exp_stall, done_reqs, ce_count, t0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_byte(13'(i));
    reset_n = 1'b0;
    ram_init = 1'b1;
    ram_rdata_q = '0;
    bus.disp_req = 1'b0;  bus.disp_addr = '0;
    bus.cpu_req = 1'b0;   bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;    bus.cpu_wdata = '0;
    bus.clr_stall = 1'b0;

    // ---- Reset state, display pass-through active during reset
    tick(); tick();
    ram_init = 1'b0;
    check("rst_cpu_ack",   32'(bus.cpu_ack), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst_ram_ce",    32'(bus.ram_ce), 0);
    check("rst_cpu_wait",  32'(bus.cpu_wait), 0);
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0055;
    #1;
    check("rst_disp_ce",   32'(bus.ram_ce), 1);
    check("rst_disp_addr", 32'(bus.ram_addr), 32'h0055);
    check("rst_disp_we",   32'(bus.ram_we), 0);
    bus.disp_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // ---- Idle display, CPU read of 0x0123
    cpu_drive(1'b0, 13'h0123, 8'h00);
    tick();
    check("rd_ack_early", 32'(bus.cpu_ack), 0);
    check("rd_wait",      32'(bus.cpu_wait), 1);
    tick();
    check("rd_ack",       32'(bus.cpu_ack), 1);
    check("rd_rdata",     32'(bus.cpu_rdata), 32'h5A);
    check("rd_stall",     32'(bus.stall_cnt), 0);

    // ---- Hold request 5 cycles after ack: no further RAM cycle
    ce_count = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ram_ce) ce_count++;
      tick();
    end
    check("hold_ram_ce_count", 32'(ce_count), 0);
    check("hold_ack",          32'(bus.cpu_ack), 1);
    bus.cpu_req = 1'b0;
    tick();
    check("release_ack",  32'(bus.cpu_ack), 0);
    check("release_wait", 32'(bus.cpu_wait), 0);

    // ---- CPU write collides with a display strobe
    cpu_drive(1'b1, 13'h1FFF, 8'hC3);
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0040;
    #1;
    check("col_disp_ce",   32'(bus.ram_ce), 1);
    check("col_disp_we",   32'(bus.ram_we), 0);
    check("col_disp_addr", 32'(bus.ram_addr), 32'h0040);
    tick();
    bus.disp_req = 1'b0;
    #1;
    check("col_disp_rdata", 32'(bus.disp_rdata), 32'(init_byte(13'h0040)));
    check("col_wr_we",      32'(bus.ram_we), 1);
    check("col_wr_addr",    32'(bus.ram_addr), 32'h1FFF);
    check("col_wr_data",    32'(bus.ram_wdata), 32'hC3);
    tick();
`ifdef VRAM_WRBUF_EN
    check("col_ack_buffered", 32'(bus.cpu_ack), 1);
    check("col_stall",        32'(bus.stall_cnt), 0);
`else
    check("col_ack_early", 32'(bus.cpu_ack), 0);
    tick();
    check("col_ack",       32'(bus.cpu_ack), 1);
    check("col_stall",     32'(bus.stall_cnt), 1);
`endif
    check("col_ram_commit", 32'(vram[13'h1FFF]), 32'hC3);
    ref_mem[13'h1FFF] = 8'hC3;
    bus.cpu_req = 1'b0;
    tick();

    // ---- Randomized traffic: periodic + random display strobes, back-to-back CPU requests
    bus.clr_stall = 1'b1;
    tick();
    bus.clr_stall = 1'b0;
    check("clr_stall", 32'(bus.stall_cnt), 0);
    active = 0; rel = 0; issued = 0; prev_disp = 0; exp_stall = 0; done_reqs = 0;
    for (int it = 0; it < 6000 && done_reqs < 100; it++) begin
      tick();
      if (prev_disp) check("rnd_disp_rdata", 32'(bus.disp_rdata), 32'(init_byte(prev_da)));
      if (rel) begin
        check("rnd_ack_release", 32'(bus.cpu_ack), 0);
        rel = 0; active = 0; done_reqs++;
      end else if (active) begin
        if (bus.cpu_ack) begin
`ifndef VRAM_WRBUF_EN
          check("rnd_ack_latency", 32'(cyc), 32'(issue_cyc + 2));
          check("rnd_stall_cnt",   32'(bus.stall_cnt), 32'(exp_stall));
`endif
          if (we_r) ref_mem[a_r] = d_r;
          else      check("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[a_r]));
          bus.cpu_req = 1'b0;
          rel = 1;
        end else if (cyc - start_cyc > 40) begin
          check("rnd_ack_timeout", 32'(bus.cpu_ack), 1);
          bus.cpu_req = 1'b0;
          rel = 1;
        end
      end
      bus.disp_req  = ((cyc % 16) == 5) || ($urandom_range(0, 7) == 0);
      bus.disp_addr = 13'($urandom_range(0, 255));
      prev_disp = bus.disp_req;
      prev_da   = bus.disp_addr;
      if (!active && !rel) begin
        we_r = ($urandom_range(0, 3) == 0);
        a_r  = 13'h1000 + 13'($urandom_range(0, 15));
        d_r  = 8'($urandom);
        cpu_drive(we_r, a_r, d_r);
        active = 1; issued = 0; start_cyc = cyc;
      end
      if (active && !rel && !issued) begin
        if (bus.disp_req) exp_stall++;
        else begin issued = 1; issue_cyc = cyc; end
      end
    end
    check("rnd_requests_done", 32'(done_reqs), 100);
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    tick(); tick(); tick();

    // ---- Stall counter saturation and clear priority
    bus.clr_stall = 1'b1;
    tick();
    bus.clr_stall = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0010;
    cpu_drive(1'b0, 13'h1005, 8'h00);
    for (int i = 0; i < 65534; i++) tick();
    check("sat_preset", 32'(bus.stall_cnt), 32'hFFFE);
    check("sat_wait",   32'(bus.cpu_wait), 1);
    tick(); tick(); tick();
    check("sat_ffff",   32'(bus.stall_cnt), 32'hFFFF);
    bus.clr_stall = 1'b1;
    tick();
    check("sat_clr_priority", 32'(bus.stall_cnt), 0);
    bus.clr_stall = 1'b0;
    bus.disp_req  = 1'b0;
    t0 = cyc;
    while (!bus.cpu_ack && cyc - t0 < 20) tick();
    check("sat_ack",   32'(bus.cpu_ack), 1);
    check("sat_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[13'h1005]));
    bus.cpu_req = 1'b0;
    tick();

`ifdef VRAM_WRBUF_EN
    // ---- Posted write then forwarded read during a display burst
    bus.disp_req = 1'b1; bus.disp_addr = 13'h0020;
    cpu_drive(1'b1, 13'h0100, 8'h77);
    tick(); tick();
    check("buf_wr_ack", 32'(bus.cpu_ack), 1);
    bus.cpu_req = 1'b0;
    tick();
    cpu_drive(1'b0, 13'h0100, 8'h00);
    tick(); tick();
    check("buf_fwd_ack",   32'(bus.cpu_ack), 1);
    check("buf_fwd_rdata", 32'(bus.cpu_rdata), 32'h77);
    bus.cpu_req = 1'b0;
    tick();
    bus.disp_req = 1'b0;
    tick(); tick(); tick();
    check("buf_drained", 32'(vram[13'h0100]), 32'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
